// File: rtl/sha3_pkg.sv
// Shared SHA3 constants and the absorb controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha3_pkg;

  // Keccak lane width in bits.
  localparam int LANE_W = 64;

  // Rate in 64-bit lanes for each SHA3 variant (rate bytes / 8).
  localparam int RATE_LANES_224 = 18;
  localparam int RATE_LANES_256 = 17;
  localparam int RATE_LANES_384 = 13;
  localparam int RATE_LANES_512 = 9;

  // pad10*1 bytes: SHA3 domain separator (01 suffix + first pad bit) and final pad bit.
  localparam logic [7:0] SHA3_DS  = 8'h06;
  localparam logic [7:0] PAD_LAST = 8'h80;

  // Absorb controller states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    EMIT_PAD,
    WAIT_PERM
  } absorb_state_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Builds one padded lane: keeps the low n_bytes of data_in, drops 0x06 right after them, ORs 0x80 into the top byte.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module sha3_pad_lane
  import sha3_pkg::*;
#(
  parameter int WIDTH = LANE_W
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       n_bytes,
  input  logic             ins_ds,
  input  logic             ins_last,
  output logic [WIDTH-1:0] lane
);

  localparam int NB = WIDTH / 8;

  // Per-byte mask, domain byte at position n_bytes, final pad bit in the top byte.
  always_comb begin
    lane = '0;
    for (int b = 0; b < NB; b++) begin
      if (4'(b) < n_bytes) begin
        lane[8*b +: 8] = data_in[8*b +: 8];
      end
      if (ins_ds && (4'(b) == n_bytes)) begin
        lane[8*b +: 8] = lane[8*b +: 8] | SHA3_DS;
      end
    end
    if (ins_last) begin
      lane[WIDTH-1 -: 8] = lane[WIDTH-1 -: 8] | PAD_LAST;
    end
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// SHA3 absorb sequencer: pops message words, pads (pad10*1, 0x06/0x80) and streams rate blocks into the state XOR path.
// Latency: FIFO pop in cycle N -> lane presented in N+2 (one data lane per 2 cycles, padding lanes one per cycle).
// Backpressure: stalls in FETCH while the FIFO is empty; holds in WAIT_PERM until the Keccak core returns perm_done.
module sha3_absorb_ctrl
  import sha3_pkg::*;
#(
  parameter int WIDTH      = LANE_W,
  parameter int RATE_LANES = RATE_LANES_256,
  parameter int LEN_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             absorb_valid,
  output logic [WIDTH-1:0] absorb_lane,
  output logic [4:0]       absorb_idx,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             busy,
  output logic             done
);

  absorb_state_t state_q, state_d;

  // Message bookkeeping.
  logic [LEN_W-1:0] rem_q;       // bytes still to be read from the FIFO
  logic [4:0]       idx_q;       // lane index of the next lane to be built
  logic             pad_done_q;  // 0x06 already placed in this message

  // Registered lane output.
  logic [WIDTH-1:0] lane_q;
  logic             lane_vld_q;
  logic [4:0]       lane_idx_q;

  // Permutation handshake and completion.
  logic launch_q;      // last lane of a block was built; fire perm_start next
  logic perm_start_q;
  logic armed_q;       // perm_start issued, waiting for the core's perm_done
  logic done_q;

  // Decode helpers.
  logic rem_zero;
  logic rem_lt8;
  logic last_idx;
  logic start_ok;
  logic perm_ack;
  logic pop;
  logic build;

  // Pad-lane inputs.
  logic [WIDTH-1:0] pad_src;
  logic [WIDTH-1:0] pad_lane;
  logic [3:0]       pad_nbytes;
  logic             pad_ds;
  logic             pad_last;

  assign rem_zero = (rem_q == '0);
  assign rem_lt8  = (rem_q < LEN_W'(8));
  // Compare saturates at the final lane so a stray idx never runs past the block.
  assign last_idx = (idx_q >= 5'(RATE_LANES - 1));
  // done_q keeps busy high for the done pulse cycle, so a start then is ignored.
  assign busy     = (state_q != IDLE) || done_q;
  assign start_ok = start && !busy;
  // perm_done only counts once our own perm_start has gone out.
  assign perm_ack = (state_q == WAIT_PERM) && armed_q && perm_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, FIFO pop request and lane-build strobe.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    build   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rem_zero) begin
          state_d = EMIT_PAD;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // fifo_data carries the word popped last cycle.
        build   = 1'b1;
        state_d = last_idx ? WAIT_PERM : FETCH;
      end
      EMIT_PAD: begin
        build = 1'b1;
        if (last_idx) begin
          state_d = WAIT_PERM;
        end
      end
      WAIT_PERM: begin
        if (perm_ack) begin
          state_d = pad_done_q ? IDLE : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_rd_en = pop && !reset;

  // Select what the pad-lane builder sees: the popped word in CAPTURE, zeros in EMIT_PAD.
  always_comb begin
    pad_src    = '0;
    pad_nbytes = 4'd0;
    pad_ds     = 1'b0;
    pad_last   = 1'b0;
    if (state_q == CAPTURE) begin
      pad_src    = fifo_data;
      pad_nbytes = rem_lt8 ? rem_q[3:0] : 4'd8;
      pad_ds     = rem_lt8;
      pad_last   = last_idx && (pad_done_q || rem_lt8);
    end else begin
      // EMIT_PAD: the lane is empty; 0x06 goes to byte 0 if not yet placed,
      // and after that padding is always complete, so the last lane gets 0x80.
      pad_nbytes = 4'd0;
      pad_ds     = !pad_done_q;
      pad_last   = last_idx;
    end
  end

  sha3_pad_lane #(
    .WIDTH (WIDTH)
  ) u_pad_lane (
    .data_in  (pad_src),
    .n_bytes  (pad_nbytes),
    .ins_ds   (pad_ds),
    .ins_last (pad_last),
    .lane     (pad_lane)
  );

  // Datapath: message counters, registered lane output and permutation handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q        <= '0;
      idx_q        <= '0;
      pad_done_q   <= 1'b0;
      lane_q       <= '0;
      lane_vld_q   <= 1'b0;
      lane_idx_q   <= '0;
      launch_q     <= 1'b0;
      perm_start_q <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      lane_vld_q   <= build;
      launch_q     <= build && last_idx;
      perm_start_q <= launch_q;
      done_q       <= perm_ack && pad_done_q;

      if (perm_start_q) begin
        armed_q <= 1'b1;
      end else if (perm_ack) begin
        armed_q <= 1'b0;
      end

      if ((state_q == IDLE) && start_ok) begin
        rem_q      <= msg_len;
        idx_q      <= '0;
        pad_done_q <= 1'b0;
      end

      if (state_q == CAPTURE) begin
        rem_q <= rem_lt8 ? '0 : (rem_q - LEN_W'(8));
      end

      if (build) begin
        lane_q     <= pad_lane;
        lane_idx_q <= idx_q;
        idx_q      <= last_idx ? 5'd0 : (idx_q + 5'd1);
        if (pad_ds) begin
          pad_done_q <= 1'b1;
        end
      end
    end
  end

  assign absorb_valid = lane_vld_q;
  assign absorb_lane  = lane_q;
  assign absorb_idx   = lane_idx_q;
  assign perm_start   = perm_start_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Scoreboard bench for sha3_absorb_ctrl with a FIFO model and a delayed-response Keccak core model.
module tb_sha3_absorb_ctrl;

  localparam int RL = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] msg_len = '0;
  logic        fifo_rd_en;
  logic [63:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        absorb_valid;
  logic [63:0] absorb_lane;
  logic [4:0]  absorb_idx;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sha3_absorb_ctrl #(
    .WIDTH      (64),
    .RATE_LANES (RL),
    .LEN_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .msg_len      (msg_len),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .absorb_valid (absorb_valid),
    .absorb_lane  (absorb_lane),
    .absorb_idx   (absorb_idx),
    .perm_start   (perm_start),
    .perm_done    (perm_done),
    .busy         (busy),
    .done         (done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after fifo_rd_en.
  logic [63:0] fifo_q[$];
  logic [63:0] msg_words[$];

  always @(posedge clk) begin
    int          sz;
    logic [63:0] w;
    sz = fifo_q.size();
    if (fifo_rd_en && sz > 0) begin
      w = fifo_q.pop_front();
      fifo_data <= w;
      sz--;
    end
    fifo_empty <= (sz == 0);
  end

  // Keccak core model: perm_done three cycles after perm_start.
  int   pcnt = 0;
  logic core_en = 1'b1;

  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (reset) begin
      pcnt <= 0;
    end else if (perm_start && core_en) begin
      pcnt <= 3;
    end else if (pcnt > 0) begin
      pcnt <= pcnt - 1;
      if (pcnt == 1) perm_done <= 1'b1;
    end
  end

  // Scoreboard and event counters.
  logic [63:0] exp_lane[$];
  logic [4:0]  exp_idx[$];
  int pops = 0;
  int perms = 0;
  int dones = 0;

  always @(negedge clk) begin
    logic [63:0] le;
    logic [4:0]  ie;
    if (!reset) begin
      if (fifo_rd_en) pops++;
      if (perm_start) perms++;
      if (done) dones++;
      if (absorb_valid) begin
        if (exp_lane.size() == 0) begin
          check("extra_lane", 64'(absorb_valid), 64'd0);
        end else begin
          le = exp_lane.pop_front();
          ie = exp_idx.pop_front();
          check($sformatf("lane%0d", ie), absorb_lane, le);
          check($sformatf("lane%0d_idx", ie), 64'(absorb_idx), 64'(ie));
        end
      end
    end
  end

  // Reference padding: byte stream, append 0x06, zero-fill to the rate, OR 0x80 into the last byte.
  task automatic build_expected(input int len);
    logic [7:0]  b[$];
    logic [63:0] w;
    logic [63:0] ln;
    for (int i = 0; i < len; i++) begin
      w = msg_words[i/8];
      b.push_back(w[8*(i%8) +: 8]);
    end
    b.push_back(8'h06);
    while ((b.size() % (8*RL)) != 0) b.push_back(8'h00);
    b[b.size()-1] = b[b.size()-1] | 8'h80;
    for (int l = 0; l < b.size()/8; l++) begin
      ln = '0;
      for (int k = 0; k < 8; k++) ln[8*k +: 8] = b[8*l + k];
      exp_lane.push_back(ln);
      exp_idx.push_back(5'(l % RL));
    end
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    start   = 1'b1;
    msg_len = 32'(len);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic run_msg(input string name, input int len, input bit stall);
    int p0, q0, d0, nw, cyc;
    p0 = pops; q0 = perms; d0 = dones;
    nw = (len + 7) / 8;
    build_expected(len);
    if (stall) fifo_q.push_back(msg_words[0]);
    else for (int i = 0; i < nw; i++) fifo_q.push_back(msg_words[i]);
    pulse_start(len);
    if (stall) begin
      cyc = 0;
      @(negedge clk);
      while (!fifo_rd_en && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      repeat (3) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        check({name, "_stall_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({name, "_stall_valid"}, 64'(absorb_valid), 64'd0);
        @(negedge clk);
      end
      for (int i = 1; i < nw; i++) fifo_q.push_back(msg_words[i]);
    end
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check({name, "_pops"}, 64'(pops - p0), 64'(nw));
    check({name, "_perm_starts"}, 64'(perms - q0), 64'(len / (8*RL) + 1));
    check({name, "_done_pulses"}, 64'(dones - d0), 64'd1);
    check({name, "_lanes_left"}, 64'(exp_lane.size()), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_absorb_valid"}, 64'(absorb_valid), 64'd0);
    check({name, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    check({name, "_perm_start"}, 64'(perm_start), 64'd0);
    check({name, "_absorb_lane"}, absorb_lane, 64'd0);
    check({name, "_absorb_idx"}, 64'(absorb_idx), 64'd0);
  endtask

  initial begin
    int q0, cyc;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Empty message: pure padding block.
    msg_words.delete();
    run_msg("len0", 0, 1'b0);

    // Short partial word.
    msg_words.delete();
    msg_words.push_back(64'hFFFF_FFFF_FFCC_BBAA);
    run_msg("len3", 3, 1'b0);

    // One byte short of the rate: 0x06 and 0x80 share the last byte.
    msg_words.delete();
    for (int i = 0; i < 17; i++) msg_words.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_msg("len135", 135, 1'b0);

    // Exactly one rate block of data: extra padding block.
    msg_words.delete();
    for (int i = 0; i < 17; i++) msg_words.push_back({$urandom, $urandom});
    run_msg("len136", 136, 1'b0);

    // Two words with the FIFO running dry before the second.
    msg_words.delete();
    for (int i = 0; i < 2; i++) msg_words.push_back({$urandom, $urandom});
    run_msg("len16_stall", 16, 1'b1);

    // Multi-block message with a partial final word.
    msg_words.delete();
    for (int i = 0; i < 25; i++) msg_words.push_back({$urandom, $urandom});
    run_msg("len197", 197, 1'b0);

    // Start while busy is ignored; reset while waiting for the permutation aborts.
    msg_words.delete();
    msg_words.push_back({$urandom, $urandom});
    build_expected(8);
    fifo_q.push_back(msg_words[0]);
    core_en = 1'b0;
    q0 = perms;
    pulse_start(8);
    @(posedge clk); #1;
    start   = 1'b1;
    msg_len = 32'd200;
    @(posedge clk); #1;
    start   = 1'b0;
    cyc = 0;
    while (!perm_start && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("busy_start_lanes_left", 64'(exp_lane.size()), 64'd0);
    check("busy_start_perm_starts", 64'(perms - q0), 64'd1);
    check("wait_perm_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    core_en = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge clk);
    check("mid_reset_still_idle", 64'(busy), 64'd0);

    // Normal message after the abort.
    msg_words.delete();
    for (int i = 0; i < 3; i++) msg_words.push_back({$urandom, $urandom});
    run_msg("after_reset_len20", 20, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha3_absorb_ctrl.md
Name: sha3_absorb_ctrl

Overview:
- Sequences the SHA3 absorb phase between the 64-bit message FIFO and the Keccak permutation core.
- Pops message words from the FIFO and masks the final partial word.
- Applies SHA3 pad10*1 padding (domain byte 0x06, final 0x80).
- Streams rate-sized blocks lane-by-lane into the state XOR path, and triggers and awaits one permutation per block.

Parameters:
- WIDTH, 64: lane and FIFO word width in bits; fixed at 64.
- RATE_LANES, 17: lanes per rate block (17 = SHA3-256, 136 bytes; 9/13/18 for the other variants).
- LEN_W, 32: width of the message byte-length input.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse to begin a message; sampled only in IDLE
- msg_len  in  LEN_W  message length in bytes; captured on start
- fifo_rd_en  out  1  FIFO pop request
- fifo_data  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- absorb_valid  out  1  absorb_lane/absorb_idx valid this cycle
- absorb_lane  out  WIDTH  padded lane to XOR into state
- absorb_idx  out  5  lane index 0..RATE_LANES-1
- perm_start  out  1  one-cycle pulse: run permutation on current state
- perm_done  in  1  one-cycle pulse from the Keccak core
- busy  out  1  high from the cycle after an accepted start through done
- done  out  1  one-cycle pulse after the final block's perm_done

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset mid-message aborts immediately; the FIFO is not flushed by this block.
- Byte order: little-endian. Byte i of a lane is bits [8i+7:8i]. Partial final word: valid bytes occupy the low bytes; the upper bytes are forced to 0.
- Registers:
  - rem: bytes remaining, loaded from msg_len on start.
  - idx: lane counter, 0..RATE_LANES-1.
  - pad_done: 0x06 already placed.
- State IDLE: on start, go to FETCH (busy=1). start while busy is ignored.
- State FETCH:
  - rem>0 and !fifo_empty: assert fifo_rd_en for one cycle, go to CAPTURE.
  - rem>0 and fifo_empty: stall in FETCH with no pop.
  - rem==0: go to EMIT_PAD (no FIFO read).
- State CAPTURE: register the lane built from fifo_data:
  - rem>=8: full word, rem-=8.
  - rem<8: keep low rem bytes, byte[rem]=0x06, pad_done=1, rem=0.
  - In both cases, absorb_valid=1 the following cycle with absorb_idx=idx.
  - Net timing: pop in cycle N, lane presented in cycle N+2. Throughput is one lane per 2 cycles.
- State EMIT_PAD: one lane per cycle, no FIFO reads.
  - Lane = 0, except byte0=0x06 if !pad_done (then set pad_done).
- Final lane byte: when idx==RATE_LANES-1 and pad_done (after the current lane's insertion), byte7 |= 0x80. If 0x06 and 0x80 land on the same byte, that byte is 0x86.
- Lane counting: after each presented lane, idx++. After lane RATE_LANES-1:
  - Pulse perm_start the next cycle, go to WAIT_PERM, idx=0.
- State WAIT_PERM: on perm_done:
  - If pad_done, pulse done and go to IDLE.
  - Otherwise go to FETCH.
  - perm_done in any other state is ignored.
- Padding boundary cases:
  - msg_len multiple of 8 (including 0): 0x06 goes to byte 0 of the next lane.
  - msg_len multiple of 8*RATE_LANES (including 0 only for the empty message): an extra full padding block is produced.
- Blocks per message: floor(msg_len/(8*RATE_LANES))+1.
- Arithmetic: rem is LEN_W bits and never underflows. idx saturates its compare at RATE_LANES-1.

Decomposition:
- Shared package sha3_pkg holds:
  - LANE_W=64.
  - Rate constants RATE_LANES_224/256/384/512 = 18/17/13/9.
  - Pad bytes SHA3_DS=8'h06 and PAD_LAST=8'h80.
  - The controller state enum {IDLE, FETCH, CAPTURE, EMIT_PAD, WAIT_PERM}.
- One sub-module, sha3_pad_lane: combinational byte mask, 0x06 insertion at byte position, and 0x80 OR for the last lane. It is instantiated once in the controller.

Test Plan:
- msg_len=0, start: no fifo_rd_en; one block with lane0=0x0000000000000006, lanes1-15=0, lane16=0x8000000000000000; one perm_start; done after perm_done.
- msg_len=3, FIFO word 0xFFFFFFFFFFCCBBAA -> lane0=0x0000000006CCBBAA, lane16=0x8000000000000000, exactly 1 pop, 1 block.
- msg_len=135, 17 words all 0xFF..FF -> lanes0-15=0xFFFFFFFFFFFFFFFF, lane16=0x86FFFFFFFFFFFFFF, 17 pops, 1 block.
- msg_len=136, 17 full words -> block1 is the data only (no 0x06/0x80); after perm_done, block2 has lane0=0x06 and lane16=0x8000000000000000; 2 perm_start pulses, 17 pops total.
- msg_len=16 with fifo_empty held high 5 cycles before the 2nd word -> controller stalls in FETCH with no pop and no absorb_valid; resumes with lane1 correct and lane2=0x06.
- Start pulse during busy, then reset asserted in WAIT_PERM -> second start ignored; after reset all outputs 0, idle, next start processes normally.
